// File: rtl/ddr_phy_rd_align_if.sv
// ddr_phy_rd_align_if
// Groups the read-data, tap and calibration signals of one DDR PHY DQ lane.
//   p_dq_in     : deserialized samples, 8 per DQ bit, index 0 earliest
//   rdata_p0/p1 : registered phase-0 / phase-1 read data per DQ bit
//   tap_ld      : manual tap load strobe, with tap_ld_val (4 bits per DQ bit)
//   tap_out     : current per-bit read-select tap
//   cal_start   : calibration start pulse
//   cal_busy    : calibration in progress
//   cal_done    : one-cycle calibration completion pulse
//   cal_fail    : per-bit flag, no passing tap found in the last calibration
// The master modport drives the lane (PHY front end / controller side);
// the slave modport is the aligner itself.
interface ddr_phy_rd_align_if #(
    parameter int DQ_WIDTH = 8
);
    logic [DQ_WIDTH*8-1:0] p_dq_in;
    logic [DQ_WIDTH-1:0]   rdata_p0;
    logic [DQ_WIDTH-1:0]   rdata_p1;
    logic                  tap_ld;
    logic [DQ_WIDTH*4-1:0] tap_ld_val;
    logic [DQ_WIDTH*4-1:0] tap_out;
    logic                  cal_start;
    logic                  cal_busy;
    logic                  cal_done;
    logic [DQ_WIDTH-1:0]   cal_fail;

    modport master (
        output p_dq_in, tap_ld, tap_ld_val, cal_start,
        input  rdata_p0, rdata_p1, tap_out, cal_busy, cal_done, cal_fail
    );

    modport slave (
        input  p_dq_in, tap_ld, tap_ld_val, cal_start,
        output rdata_p0, rdata_p1, tap_out, cal_busy, cal_done, cal_fail
    );
endinterface

// File: rtl/ddr_phy_rd_align.sv
// ddr_phy_rd_align
// Per-bit read-data alignment for one DDR PHY lane. Each DQ bit selects its
// phase-0/phase-1 sample out of a 24-sample window (two cycles of history
// plus the current deserialized byte) using a tap. A calibration sweep tries
// every tap against a known pattern and centres each bit in its longest run
// of passing taps.
// Ports:
//   clk100m : single rising-edge clock
//   phy_rst : asynchronous active-high reset
//   bus     : ddr_phy_rd_align_if.slave (data, taps, calibration control)
module ddr_phy_rd_align #(
    parameter int   DQ_WIDTH   = 8,
    parameter int   TAPS       = 12,
    parameter int   TAP_INIT   = 6,
    parameter int   SETTLE_CYC = 4,
    parameter int   CMP_CYC    = 16,
    parameter logic EXP_P0     = 1'b0,
    parameter logic EXP_P1     = 1'b1
) (
    input logic               clk100m,
    input logic               phy_rst,
    ddr_phy_rd_align_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETTLE, COMPARE, NEXT, FINISH} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] CMP_LAST    = 16'(CMP_CYC - 1);
    localparam logic [3:0]  TAP_LAST    = 4'(TAPS - 1);
    localparam logic [3:0]  TAP_RST     = 4'(TAP_INIT);

    state_t                state;
    state_t                state_nxt;
    logic [15:0]           phase_cnt;
    logic [3:0]            sweep_tap;
    logic [DQ_WIDTH*8-1:0] q1;
    logic [DQ_WIDTH*8-1:0] q2;
    logic [DQ_WIDTH-1:0]   pass;
    logic [3:0]            run_start     [DQ_WIDTH];
    logic [3:0]            run_len       [DQ_WIDTH];
    logic [3:0]            best_start    [DQ_WIDTH];
    logic [3:0]            best_len      [DQ_WIDTH];
    logic [3:0]            run_start_nxt [DQ_WIDTH];
    logic [3:0]            run_len_nxt   [DQ_WIDTH];
    logic [3:0]            centre        [DQ_WIDTH];
    logic [23:0]           window        [DQ_WIDTH];
    logic [4:0]            eff_tap       [DQ_WIDTH];

    // Out-of-range taps (manual loads can reach 15) saturate to the last tap.
    function automatic logic [3:0] clamp_tap(input logic [3:0] k);
        if (k > TAP_LAST) return TAP_LAST;
        return k;
    endfunction

    assign bus.cal_busy = (state != IDLE);

    // Build each bit's sample window and pick the tap it reads through: the
    // sweep tap while calibrating, otherwise the bit's own programmed tap.
    always_comb begin
        for (int b = 0; b < DQ_WIDTH; b++) begin
            window[b]  = {q2[8*b +: 8], q1[8*b +: 8], bus.p_dq_in[8*b +: 8]};
            eff_tap[b] = {1'b0, clamp_tap(bus.cal_busy ? sweep_tap : bus.tap_out[4*b +: 4])};
        end
    end

    // Sample history and registered read data; phase 1 sits four samples
    // later in the window than phase 0.
    always_ff @(posedge clk100m or posedge phy_rst) begin
        if (phy_rst) begin
            q1           <= '0;
            q2           <= '0;
            bus.rdata_p0 <= '0;
            bus.rdata_p1 <= '0;
        end else begin
            q1 <= bus.p_dq_in;
            q2 <= q1;
            for (int b = 0; b < DQ_WIDTH; b++) begin
                bus.rdata_p1[b] <= window[b][eff_tap[b] + 5'd7];
                bus.rdata_p0[b] <= window[b][eff_tap[b] + 5'd3];
            end
        end
    end

    // Calibration sequencer: per tap, SETTLE then COMPARE then one NEXT
    // cycle for bookkeeping; FINISH commits the results.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cal_start) state_nxt = SETTLE;
            SETTLE:  if (phase_cnt == SETTLE_LAST) state_nxt = COMPARE;
            COMPARE: if (phase_cnt == CMP_LAST) state_nxt = NEXT;
            NEXT:    state_nxt = (sweep_tap == TAP_LAST) ? FINISH : SETTLE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, per-phase cycle counter and the sweep tap index.
    always_ff @(posedge clk100m or posedge phy_rst) begin
        if (phy_rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            sweep_tap <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE) phase_cnt <= '0;
            else phase_cnt <= phase_cnt + 16'd1;
            if (state == IDLE && bus.cal_start) sweep_tap <= '0;
            else if (state == NEXT && state_nxt == SETTLE) sweep_tap <= sweep_tap + 4'd1;
        end
    end

    // Run tracking: a zero run length means no run is open, so a passing
    // tap opens a new run starting at the current sweep tap.
    always_comb begin
        for (int b = 0; b < DQ_WIDTH; b++) begin
            run_start_nxt[b] = run_start[b];
            run_len_nxt[b]   = 4'd0;
            if (pass[b]) begin
                if (run_len[b] == 4'd0) begin
                    run_start_nxt[b] = sweep_tap;
                    run_len_nxt[b]   = 4'd1;
                end else begin
                    run_len_nxt[b] = run_len[b] + 4'd1;
                end
            end
            centre[b] = best_start[b] + ((best_len[b] - 4'd1) >> 1);
        end
    end

    // Pass flags, run/best trackers, tap register and calibration results.
    // The best run only moves on a strictly longer run, so ties keep the
    // earliest one.
    always_ff @(posedge clk100m or posedge phy_rst) begin
        if (phy_rst) begin
            pass         <= '0;
            bus.tap_out  <= {DQ_WIDTH{TAP_RST}};
            bus.cal_fail <= '0;
            bus.cal_done <= 1'b0;
            for (int b = 0; b < DQ_WIDTH; b++) begin
                run_start[b]  <= '0;
                run_len[b]    <= '0;
                best_start[b] <= '0;
                best_len[b]   <= '0;
            end
        end else begin
            bus.cal_done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (bus.cal_start) begin
                        pass <= '0;
                        for (int b = 0; b < DQ_WIDTH; b++) begin
                            run_start[b]  <= '0;
                            run_len[b]    <= '0;
                            best_start[b] <= '0;
                            best_len[b]   <= '0;
                        end
                    end else if (bus.tap_ld) begin
                        bus.tap_out <= bus.tap_ld_val;
                    end
                end
                SETTLE: if (state_nxt == COMPARE) pass <= '1;
                COMPARE: begin
                    for (int b = 0; b < DQ_WIDTH; b++) begin
                        if ({bus.rdata_p0[b], bus.rdata_p1[b]} != {EXP_P0, EXP_P1}) pass[b] <= 1'b0;
                    end
                end
                NEXT: begin
                    for (int b = 0; b < DQ_WIDTH; b++) begin
                        run_start[b] <= run_start_nxt[b];
                        run_len[b]   <= run_len_nxt[b];
                        if (run_len_nxt[b] > best_len[b]) begin
                            best_start[b] <= run_start_nxt[b];
                            best_len[b]   <= run_len_nxt[b];
                        end
                    end
                end
                FINISH: begin
                    for (int b = 0; b < DQ_WIDTH; b++) begin
                        if (best_len[b] != 4'd0) begin
                            bus.tap_out[4*b +: 4] <= centre[b];
                            bus.cal_fail[b]       <= 1'b0;
                        end else begin
                            bus.cal_fail[b] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
